// File: rtl/ram_responder.sv
// Byte-addressed 256 x 8 big-endian RAM that answers an MFA/MOC handshake
// after a configurable number of BUSY wait cycles.
module ram_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic [7:0]  ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MOC,
    output logic        ERR
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_d;
    logic        moc_d, err_d;
    logic        wr_en;
    logic        bad;
    logic [31:0] rdata;
    logic [7:0]  a1, a2, a3;

    logic [7:0] mem [256];

    // Aligned accesses never cross 255, so these sums never need to wrap.
    assign a1 = addr_q + 8'd1;
    assign a2 = addr_q + 8'd2;
    assign a3 = addr_q + 8'd3;

    assign bad = (size_q == 2'b11) ||
                 ((size_q == SzHalf) && addr_q[0]) ||
                 ((size_q == SzWord) && (addr_q[1:0] != 2'b00));

    always_comb begin
        rdata = '0;
        case (size_q)
            SzByte:  rdata = {24'b0, mem[addr_q]};
            SzHalf:  rdata = {16'b0, mem[addr_q], mem[a1]};
            SzWord:  rdata = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        dout_d  = DATA_OUT;
        moc_d   = MOC;
        err_d   = ERR;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MFA) begin
                    addr_d  = ADDR;
                    rw_d    = RW;
                    size_d  = SIZE;
                    wdata_d = DATA_IN;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Dropping MFA mid-wait abandons the access with no side effects.
                if (!MFA) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    moc_d   = 1'b1;
                    err_d   = bad;
                    state_d = StDone;
                    if (!bad) begin
                        if (rw_q) dout_d = rdata;
                        else      wr_en  = 1'b1;
                    end
                end
            end
            StDone: begin
                if (!MFA) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            size_q   <= '0;
            wdata_q  <= '0;
            DATA_OUT <= '0;
            MOC      <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            DATA_OUT <= dout_d;
            MOC      <= moc_d;
            ERR      <= err_d;
        end
    end

    // Array has no reset so its contents survive CLR.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            case (size_q)
                SzByte: mem[addr_q] <= wdata_q[7:0];
                SzHalf: begin
                    mem[addr_q] <= wdata_q[15:8];
                    mem[a1]     <= wdata_q[7:0];
                end
                SzWord: begin
                    mem[addr_q] <= wdata_q[31:24];
                    mem[a1]     <= wdata_q[23:16];
                    mem[a2]     <= wdata_q[15:8];
                    mem[a3]     <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra BUSY cycles before the access completes; legal range 0..15.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 CLR  input  1  reset; asynchronous, active-low.
REQ-004 MFA  input  1  memory function active; the datapath's request strobe, level-held until MOC.
REQ-005 RW  input  1  1 = read, 0 = write.
REQ-006 SIZE  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 ADDR  input  8  byte address, driven from the datapath MAR.
REQ-008 DATA_IN  input  32  write data, driven from the datapath MDR; byte/halfword data sits in the low bits.
REQ-009 DATA_OUT  output  32  read data to the MDR input.
REQ-010 MOC  output  1  memory operation complete.
REQ-011 ERR  output  1  access rejected; valid while MOC = 1.

Function
REQ-012 Storage SHALL be a 256 x 8 byte array, big-endian: the word at A has its MSB at A and its LSB at A+3.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 IDLE with MFA = 1 at an edge: ADDR/RW/SIZE/DATA_IN SHALL be latched, counter loaded with WAIT_CYCLES, go to BUSY.
REQ-015 Input changes after the latch edge SHALL be ignored for that transaction.
REQ-016 BUSY with counter != 0: decrement and stay in BUSY.
REQ-017 BUSY with counter == 0: perform the access, set MOC = 1, go to DONE.
REQ-018 MOC SHALL therefore rise on the (WAIT_CYCLES+1)th rising edge after the latch edge.
REQ-019 BUSY with MFA = 0 SHALL abort: go to IDLE with no array write, DATA_OUT unchanged, MOC = 0.
REQ-020 DONE: MOC and ERR SHALL hold while MFA = 1.
REQ-021 DONE with MFA = 0: MOC = 0, ERR = 0, go to IDLE.
REQ-022 A new request SHALL need MFA sampled 0 at least once after DONE; MFA held high never starts a second access.
REQ-023 Byte read: DATA_OUT = {24'b0, mem[A]}.
REQ-024 Halfword read: DATA_OUT = {16'b0, mem[A], mem[A+1]}.
REQ-025 Word read: DATA_OUT = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
REQ-026 Byte write SHALL store DATA_IN[7:0].
REQ-027 Halfword write SHALL store DATA_IN[15:8] at A and DATA_IN[7:0] at A+1.
REQ-028 Word write SHALL store DATA_IN[31:24] at A through DATA_IN[7:0] at A+3.
REQ-029 Writes SHALL leave DATA_OUT unchanged.
REQ-030 Misaligned or illegal access (SIZE = 01 with A[0] = 1; SIZE = 10 with A[1:0] != 00; SIZE = 11): no array write, DATA_OUT unchanged, and MOC = 1 with ERR = 1 at the normal completion edge.
REQ-031 Aligned accesses cannot cross address 255; no wrap-around logic SHALL exist.
REQ-032 DATA_OUT SHALL hold its last read value until the next successful read.

Reset
REQ-033 CLR = 0 SHALL immediately force state = IDLE, counter = 0, DATA_OUT = 0, MOC = 0, ERR = 0, independent of CLK.
REQ-034 Array contents SHALL NOT be cleared by CLR; they are retained across reset.
REQ-035 CLR asserted in BUSY SHALL cancel the transaction with no array write.
REQ-036 After CLR returns to 1 with MFA = 1, a new transaction SHALL start at the next edge (state is IDLE).

Verification
REQ-037 Word write then read-back: write 0xDEADBEEF to 0x10; word read 0x10 -> DATA_OUT = 0xDEADBEEF, ERR = 0, MOC on the 3rd edge after the latch (WAIT_CYCLES = 2).
REQ-038 Endianness: after REQ-037, byte read 0x10 -> 0x000000DE; byte read 0x13 -> 0x000000EF; halfword read 0x12 -> 0x0000BEEF.
REQ-039 Sub-word writes: byte write 0xA5 to 0x11, then word read 0x10 -> 0xDEA5BEEF.
REQ-040 Halfword write 0x1234 to 0x20, then word read 0x20 -> 0x1234xxxx, with prior bytes 0x22–0x23 intact.
REQ-041 Misalignment: word write to 0x11 -> MOC = 1, ERR = 1, and word read 0x10 is unchanged.
REQ-042 SIZE = 11 -> ERR = 1.
REQ-043 Handshake: hold MFA = 1 for 10 cycles after MOC -> exactly one access, MOC stays high; drop MFA -> MOC = 0 next edge.
REQ-044 Abort: drop MFA during BUSY of a write -> MOC never rises and the target byte is unchanged.
REQ-045 Reset: pulse CLR low during BUSY of a write -> MOC = 0, DATA_OUT = 0 immediately; no write occurs; earlier-written data reads back intact after release.
REQ-046 Parameter sweep at WAIT_CYCLES = 0: MOC on the 1st edge after the latch.
REQ-047 Parameter sweep at WAIT_CYCLES = 15: MOC on the 16th edge after the latch.
